task_join_collector: RTL and testbench
======================================

TASK_JOIN_COLLECTOR -- requirements
Module: task_join_collector

Interface
REQ-001 The block SHALL have parameter N_TASKS, default 2, giving the number of parallel worker tasks in one fork group.
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of the join latency counter.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port fork_valid, input, 1 bit: request to launch a fork group.
REQ-006 The block SHALL have port fork_ready, output, 1 bit: group launch accepted this cycle when high with fork_valid.
REQ-007 The block SHALL have port mode, input, 2 bits, sampled at fork accept: 00 JOIN_ALL, 01 JOIN_ANY, 10 JOIN_NONE, 11 treated as JOIN_ALL.
REQ-008 The block SHALL have port task_start, output, N_TASKS bits: one-cycle launch pulse per worker.
REQ-009 The block SHALL have port task_done, input, N_TASKS bits: one-cycle completion pulse per worker.
REQ-010 The block SHALL have port join_valid, output, 1 bit: join condition met, parent may proceed.
REQ-011 The block SHALL have port join_ready, input, 1 bit: parent acknowledges the join.
REQ-012 The block SHALL have port join_mask, output, N_TASKS bits: workers completed at join time.
REQ-013 The block SHALL have port join_cycles, output, CNT_W bits: WAIT cycles from launch to join.
REQ-014 The block SHALL have port busy, output, 1 bit: at least one launched worker still outstanding.

Function
REQ-015 The block SHALL implement states IDLE, WAIT and JOIN, plus an outstanding[N_TASKS] register independent of state.
REQ-016 The block SHALL drive fork_ready = (state==IDLE) && (outstanding==0), so no re-fork happens while any worker of the prior group runs.
REQ-017 On accept at edge k, the block SHALL pulse task_start to all ones for exactly cycle k+1, set outstanding to all ones, clear the completed mask and join_cycles, and latch mode.
REQ-018 Each edge, the block SHALL clear outstanding bits where task_done=1; done on a bit already clear is ignored; busy = |outstanding.
REQ-019 A done pulse in the task_start cycle SHALL be counted (zero-latency worker).
REQ-020 In WAIT, the completed mask SHALL accumulate task_done & outstanding; condition is mask==all ones (JOIN_ALL) or mask!=0 (JOIN_ANY), including the current-cycle done.
REQ-021 When the condition is met, the block SHALL go WAIT->JOIN; join_valid rises next cycle, join_mask equals the accumulated mask including the completing done(s), and join_cycles equals the WAIT cycle index of completion (task_start cycle = 0).
REQ-022 join_cycles SHALL increment once per WAIT cycle without completion and saturate at 2^CNT_W-1.
REQ-023 JOIN_NONE SHALL go IDLE->JOIN directly: join_valid and task_start both first high in cycle k+1, join_mask=0, join_cycles=0.
REQ-024 join_valid, join_mask and join_cycles SHALL hold stable while join_valid=1 and join_ready=0; later done pulses update only outstanding/busy.
REQ-025 The join_valid && join_ready handshake SHALL return the block to IDLE; fork is not accepted in that same cycle.
REQ-026 After JOIN_ANY or JOIN_NONE, busy SHALL stay high until all remaining dones arrive, and fork_ready SHALL rise the cycle after the last done.

Reset
REQ-027 With rst_n=0 at a clock edge, the block SHALL enter IDLE and clear outstanding, mask, join_cycles, task_start, join_valid, join_mask and busy to 0; fork_ready SHALL be 1 the cycle after release.
REQ-028 Reset during WAIT or JOIN SHALL abandon the group; late task_done pulses after reset SHALL be ignored.

Verification
REQ-029 JOIN_ALL, N=2, done[0] at WAIT index 20, done[1] at 30 -> join_valid next cycle, join_cycles=30, join_mask=11, busy=0.
REQ-030 JOIN_ANY, same stimulus -> join at index 20, join_mask=01, busy=1 until done[1], fork_ready rises the cycle after done[1].
REQ-031 JOIN_NONE -> join_valid with task_start in cycle k+1, join_mask=00, join_cycles=0; fork_ready=0 until both dones arrive.
REQ-032 JOIN_ANY with done=11 in one cycle -> join_mask=11; with join_ready=0 for 5 cycles, outputs stay stable.
REQ-033 rst_n=0 at WAIT index 10 -> all outputs 0 next cycle; done[1] at index 30 ignored; fork_ready=1 after release.
REQ-034 JOIN_ALL with no dones for 2^CNT_W+5 cycles -> join_cycles saturates at 2^CNT_W-1, join_valid stays 0.

Source files
------------

// File: rtl/task_join_collector.sv
// Fork/join controller: launches N_TASKS workers, joins on ALL/ANY/NONE, reports mask and WAIT latency.
// task_start/join_valid are registered (1 cycle after accept); join outputs hold until join_ready.
module task_join_collector #(
  parameter int N_TASKS = 2,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fork_valid,
  output logic               fork_ready,
  input  logic [1:0]         mode,
  output logic [N_TASKS-1:0] task_start,
  input  logic [N_TASKS-1:0] task_done,
  output logic               join_valid,
  input  logic               join_ready,
  output logic [N_TASKS-1:0] join_mask,
  output logic [CNT_W-1:0]   join_cycles,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, WAIT, JOIN} state_t;

  localparam logic [1:0]         MODE_ANY  = 2'b01;
  localparam logic [1:0]         MODE_NONE = 2'b10;
  localparam logic [N_TASKS-1:0] ALL_ONES  = {N_TASKS{1'b1}};
  localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]   CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [N_TASKS-1:0] outstanding_q, outstanding_d;
  logic [N_TASKS-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         mode_q, mode_d;
  logic [N_TASKS-1:0] start_q, start_d;
  logic               jvld_q, jvld_d;
  logic               join_cond;

  assign fork_ready  = (state_q == IDLE) && (outstanding_q == '0);
  assign task_start  = start_q;
  assign join_valid  = jvld_q;
  assign join_mask   = mask_q;
  assign join_cycles = cnt_q;
  assign busy        = |outstanding_q;

  always_comb begin
    state_d       = state_q;
    outstanding_d = outstanding_q & ~task_done;
    mask_d        = mask_q;
    cnt_d         = cnt_q;
    mode_d        = mode_q;
    start_d       = '0;
    jvld_d        = jvld_q;
    join_cond     = 1'b0;
    case (state_q)
      IDLE: begin
        if (fork_valid && fork_ready) begin
          start_d       = ALL_ONES;
          outstanding_d = ALL_ONES;
          mask_d        = '0;
          cnt_d         = '0;
          mode_d        = mode;
          if (mode == MODE_NONE) begin
            state_d = JOIN;
            jvld_d  = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        // Current-cycle dones count toward the condition; mode 11 falls through to JOIN_ALL.
        mask_d    = mask_q | (task_done & outstanding_q);
        join_cond = (mode_q == MODE_ANY) ? (|mask_d) : (&mask_d);
        if (join_cond) begin
          state_d = JOIN;
          jvld_d  = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      JOIN: begin
        if (join_ready) begin
          state_d = IDLE;
          jvld_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        jvld_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      outstanding_q <= '0;
      mask_q        <= '0;
      cnt_q         <= '0;
      mode_q        <= 2'b00;
      start_q       <= '0;
      jvld_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      mask_q        <= mask_d;
      cnt_q         <= cnt_d;
      mode_q        <= mode_d;
      start_q       <= start_d;
      jvld_q        <= jvld_d;
    end
  end

endmodule

// File: tb/tb_task_join_collector.sv
// Directed bench for task_join_collector: vector table for join modes plus hand sequences.
module tb_task_join_collector;
  localparam int N  = 2;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fork_valid;
  logic          fork_ready;
  logic [1:0]    mode;
  logic [N-1:0]  task_start;
  logic [N-1:0]  task_done;
  logic          join_valid;
  logic          join_ready;
  logic [N-1:0]  join_mask;
  logic [CW-1:0] join_cycles;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  task_join_collector #(.N_TASKS(N), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fork_valid (fork_valid),
    .fork_ready (fork_ready),
    .mode       (mode),
    .task_start (task_start),
    .task_done  (task_done),
    .join_valid (join_valid),
    .join_ready (join_ready),
    .join_mask  (join_mask),
    .join_cycles(join_cycles),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    int         t0;
    int         t1;
    int         exp_idx;
    logic [1:0] exp_mask;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fork_group(input logic [1:0] m);
    fork_valid = 1'b1;
    mode       = m;
    chk("fork_ready_before_accept", {31'd0, fork_ready}, 1);
    tick();
    fork_valid = 1'b0;
    mode       = 2'b00;
  endtask

  initial begin
    vecs[0] = '{2'b00, 20, 30, 30, 2'b11, 1'b0};
    vecs[1] = '{2'b01, 20, 30, 20, 2'b01, 1'b1};
    vecs[2] = '{2'b00,  5,  5,  5, 2'b11, 1'b0};
    vecs[3] = '{2'b01, 12,  3,  3, 2'b10, 1'b1};
    vecs[4] = '{2'b00,  0,  0,  0, 2'b11, 1'b0};
    vecs[5] = '{2'b11,  7,  2,  7, 2'b11, 1'b0};
    vecs[6] = '{2'b01,  4,  4,  4, 2'b11, 1'b0};

    rst_n = 1'b0; fork_valid = 1'b0; mode = 2'b00; task_done = '0; join_ready = 1'b1;
    tick(); tick();
    chk("rst_task_start", {30'd0, task_start}, 0);
    chk("rst_join_valid", {31'd0, join_valid}, 0);
    chk("rst_join_mask", {30'd0, join_mask}, 0);
    chk("rst_join_cycles", {24'd0, join_cycles}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    rst_n = 1'b1;
    tick();
    chk("rst_release_fork_ready", {31'd0, fork_ready}, 1);

    // Table vectors with join_ready held high.
    for (int v = 0; v < 7; v++) begin
      int  last;
      logic seen;
      last = (vecs[v].t0 > vecs[v].t1) ? vecs[v].t0 : vecs[v].t1;
      seen = 1'b0;
      fork_group(vecs[v].mode);
      chk("vec_task_start", {30'd0, task_start}, 2'b11);
      for (int idx = 0; idx < 40; idx++) begin
        task_done = {(vecs[v].t1 == idx), (vecs[v].t0 == idx)};
        tick();
        if (join_valid && !seen) begin
          seen = 1'b1;
          chk("vec_join_index", idx, vecs[v].exp_idx);
          chk("vec_join_cycles", {24'd0, join_cycles}, vecs[v].exp_idx);
          chk("vec_join_mask", {30'd0, join_mask}, {30'd0, vecs[v].exp_mask});
          chk("vec_busy_at_join", {31'd0, busy}, {31'd0, vecs[v].exp_busy});
        end
        if (vecs[v].exp_busy) begin
          if (idx == last - 1) chk("vec_fork_ready_before_last", {31'd0, fork_ready}, 0);
          if (idx == last) chk("vec_fork_ready_after_last", {31'd0, fork_ready}, 1);
        end
      end
      task_done = '0;
      chk("vec_join_seen", {31'd0, seen}, 1);
      chk("vec_busy_end", {31'd0, busy}, 0);
      chk("vec_fork_ready_end", {31'd0, fork_ready}, 1);
    end

    // JOIN_NONE: join and launch in the same cycle, re-fork blocked until all done.
    join_ready = 1'b0;
    fork_group(2'b10);
    chk("none_task_start", {30'd0, task_start}, 2'b11);
    chk("none_join_valid", {31'd0, join_valid}, 1);
    chk("none_join_mask", {30'd0, join_mask}, 0);
    chk("none_join_cycles", {24'd0, join_cycles}, 0);
    chk("none_busy", {31'd0, busy}, 1);
    chk("none_fork_ready", {31'd0, fork_ready}, 0);
    tick();
    chk("none_task_start_pulse", {30'd0, task_start}, 0);
    chk("none_join_hold", {31'd0, join_valid}, 1);
    join_ready = 1'b1;
    task_done  = 2'b01;
    tick();
    task_done  = '0;
    chk("none_join_acked", {31'd0, join_valid}, 0);
    chk("none_busy_partial", {31'd0, busy}, 1);
    repeat (3) tick();
    chk("none_fork_ready_partial", {31'd0, fork_ready}, 0);
    task_done = 2'b10;
    tick();
    task_done = '0;
    chk("none_busy_done", {31'd0, busy}, 0);
    chk("none_fork_ready_done", {31'd0, fork_ready}, 1);

    // JOIN_ANY, both done together, parent stalls five cycles.
    join_ready = 1'b0;
    fork_group(2'b01);
    tick(); tick();
    task_done = 2'b11;
    tick();
    task_done = '0;
    chk("stall_join_valid", {31'd0, join_valid}, 1);
    chk("stall_join_mask", {30'd0, join_mask}, 2'b11);
    chk("stall_join_cycles", {24'd0, join_cycles}, 2);
    chk("stall_busy", {31'd0, busy}, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_hold_valid", {31'd0, join_valid}, 1);
      chk("stall_hold_mask", {30'd0, join_mask}, 2'b11);
      chk("stall_hold_cycles", {24'd0, join_cycles}, 2);
      chk("stall_hold_fork_ready", {31'd0, fork_ready}, 0);
    end
    join_ready = 1'b1;
    fork_valid = 1'b1;
    tick();
    fork_valid = 1'b0;
    chk("ack_join_valid", {31'd0, join_valid}, 0);
    chk("ack_no_same_cycle_fork", {30'd0, task_start}, 0);
    chk("ack_fork_ready", {31'd0, fork_ready}, 1);

    // Reset mid-WAIT abandons the group; late done ignored.
    fork_group(2'b00);
    for (int idx = 0; idx < 10; idx++) tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_task_start", {30'd0, task_start}, 0);
    chk("midrst_join_valid", {31'd0, join_valid}, 0);
    chk("midrst_join_mask", {30'd0, join_mask}, 0);
    chk("midrst_join_cycles", {24'd0, join_cycles}, 0);
    chk("midrst_busy", {31'd0, busy}, 0);
    rst_n = 1'b1;
    chk("midrst_fork_ready", {31'd0, fork_ready}, 1);
    for (int idx = 11; idx < 40; idx++) begin
      task_done = (idx == 30) ? 2'b10 : 2'b00;
      tick();
    end
    task_done = '0;
    chk("late_done_busy", {31'd0, busy}, 0);
    chk("late_done_join_valid", {31'd0, join_valid}, 0);
    chk("late_done_fork_ready", {31'd0, fork_ready}, 1);

    // Counter saturation with JOIN_ALL and no dones.
    fork_group(2'b00);
    for (int idx = 0; idx < (1 << CW) + 5; idx++) begin
      tick();
      if (idx == 199) chk("sat_mid_count", {24'd0, join_cycles}, 200);
    end
    chk("sat_join_cycles", {24'd0, join_cycles}, (1 << CW) - 1);
    chk("sat_join_valid", {31'd0, join_valid}, 0);
    task_done = 2'b11;
    tick();
    task_done = '0;
    chk("sat_final_join_valid", {31'd0, join_valid}, 1);
    chk("sat_final_cycles", {24'd0, join_cycles}, (1 << CW) - 1);
    chk("sat_final_mask", {30'd0, join_mask}, 2'b11);
    tick();
    chk("sat_final_idle", {31'd0, fork_ready}, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
